// File: rtl/trivium_pkg.sv
// Trivium shared definitions: state geometry, tap positions, FSM encoding and key/IV load image.
package trivium_pkg;

    localparam int STATE_W = 288;
    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;

    localparam int T66  = 66;
    localparam int T69  = 69;
    localparam int T91  = 91;
    localparam int T92  = 92;
    localparam int T93  = 93;
    localparam int T162 = 162;
    localparam int T171 = 171;
    localparam int T175 = 175;
    localparam int T176 = 176;
    localparam int T177 = 177;
    localparam int T243 = 243;
    localparam int T264 = 264;
    localparam int T286 = 286;
    localparam int T287 = 287;
    localparam int T288 = 288;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } fsm_t;

    // State vector keeps s1 at the MSB, so s_i lives at bit STATE_W-i.
    function automatic logic sbit(input logic [STATE_W-1:0] st, input int idx);
        return st[STATE_W-idx];
    endfunction

    function automatic logic [STATE_W-1:0] load_image(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        return {key, 13'b0, iv, 4'b0, 108'b0, 3'b111};
    endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: produces keystream bit z and the shifted next state.
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] s_in,
    output logic [STATE_W-1:0] s_out,
    output logic               z
);

    logic t1_lin, t2_lin, t3_lin;
    logic t1, t2, t3;

    assign t1_lin = sbit(s_in, T66)  ^ sbit(s_in, T93);
    assign t2_lin = sbit(s_in, T162) ^ sbit(s_in, T177);
    assign t3_lin = sbit(s_in, T243) ^ sbit(s_in, T288);
    assign z      = t1_lin ^ t2_lin ^ t3_lin;

    assign t1 = t1_lin ^ (sbit(s_in, T91)  & sbit(s_in, T92))  ^ sbit(s_in, T171);
    assign t2 = t2_lin ^ (sbit(s_in, T175) & sbit(s_in, T176)) ^ sbit(s_in, T264);
    assign t3 = t3_lin ^ (sbit(s_in, T286) & sbit(s_in, T287)) ^ sbit(s_in, T69);

    // Whole register shifts one place toward s288; the three register heads take the feedbacks.
    always_comb begin
        s_out                     = {t3, s_in[STATE_W-1:1]};
        s_out[STATE_W-(T93+1)]    = t1;
        s_out[STATE_W-(T177+1)]   = t2;
    end

endmodule

// File: rtl/trivium_keystream.sv
// Trivium keystream generator, W bits/cycle over valid/ready; output holds while stalled.
// Load -> INIT_ROUNDS/W busy cycles -> RUN. TRIVIUM_STATE_OUT_EN adds debug port state_o.
module trivium_keystream
    import trivium_pkg::*;
#(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [IV_W-1:0]    iv_i,
    input  logic               load_i,
    input  logic               clear_i,
    output logic               busy_o,
    output logic               ks_valid_o,
    input  logic               ks_ready_i,
`ifdef TRIVIUM_STATE_OUT_EN
    output logic [W-1:0]       ks_data_o,
    output logic [STATE_W-1:0] state_o
`else
    output logic [W-1:0]       ks_data_o
`endif
);

    localparam int CYC   = INIT_ROUNDS / W;
    localparam int CNT_W = $clog2(CYC + 1);

    fsm_t               fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] st_q, st_d;

    logic [STATE_W-1:0] chain [0:W];
    logic [W-1:0]       z_w;

    assign chain[0] = st_q;

    // Round k produces keystream bit z(n+k), which lands at ks_data_o[W-1-k].
    for (genvar k = 0; k < W; k++) begin : g_round
        trivium_round u_round (
            .s_in  (chain[k]),
            .s_out (chain[k+1]),
            .z     (z_w[W-1-k])
        );
    end

    assign busy_o     = (fsm_q == WARMUP);
    assign ks_valid_o = (fsm_q == RUN);
    assign ks_data_o  = z_w;

`ifdef TRIVIUM_STATE_OUT_EN
    assign state_o = st_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        if (clear_i) begin
            fsm_d = IDLE;
            cnt_d = '0;
            st_d  = '0;
        end else if (load_i) begin
            fsm_d = WARMUP;
            cnt_d = '0;
            st_d  = load_image(key_i, iv_i);
        end else begin
            unique case (fsm_q)
                WARMUP: begin
                    st_d  = chain[W];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CYC - 1)) fsm_d = RUN;
                end
                RUN: begin
                    if (ks_ready_i) st_d = chain[W];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_keystream.sv
// Self-checking bench for trivium_keystream against a bit-serial Trivium reference model.
module tb_trivium_keystream;

    localparam int W           = 8;
    localparam int INIT_ROUNDS = 1152;
    localparam int CYC         = INIT_ROUNDS / W;

    logic          clk = 1'b0;
    logic          reset;
    logic [79:0]   key_i, iv_i;
    logic          load_i, clear_i, ks_ready_i;
    logic          busy_o, ks_valid_o;
    logic [W-1:0]  ks_data_o;
`ifdef TRIVIUM_STATE_OUT_EN
    logic [287:0]  state_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit ms [1:288];
    bit mq [$];

    always #5 clk = ~clk;

    trivium_keystream #(.W(W), .INIT_ROUNDS(INIT_ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_i      (key_i),
        .iv_i       (iv_i),
        .load_i     (load_i),
        .clear_i    (clear_i),
        .busy_o     (busy_o),
        .ks_valid_o (ks_valid_o),
        .ks_ready_i (ks_ready_i),
`ifdef TRIVIUM_STATE_OUT_EN
        .ks_data_o  (ks_data_o),
        .state_o    (state_o)
`else
        .ks_data_o  (ks_data_o)
`endif
    );

    // ---------------- reference model ----------------
    task automatic model_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) ms[i]      = k[80-i];
        for (int i = 1; i <= 80; i++) ms[93+i]   = v[80-i];
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        mq.delete();
    endtask

    task automatic model_round(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3; ms[94] = t1; ms[178] = t2;
    endtask

    task automatic model_start(input logic [79:0] k, input logic [79:0] v, input int nbits);
        bit z;
        model_load(k, v);
        repeat (INIT_ROUNDS) model_round(z);
        for (int i = 0; i < nbits; i++) begin
            model_round(z);
            mq.push_back(z);
        end
    endtask

    function automatic logic [287:0] model_image();
        logic [287:0] img;
        for (int i = 1; i <= 288; i++) img[288-i] = ms[i];
        return img;
    endfunction

    function automatic logic [W-1:0] exp_word();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < W; k++)
            if (mq.size() > 0) w[W-1-k] = mq.pop_front();
        return w;
    endfunction

    function automatic logic [79:0] rand80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [79:0] k, input logic [79:0] v);
        key_i  = k;
        iv_i   = v;
        load_i = 1'b1;
        wait_cycle();
        load_i = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 4*CYC + 10) begin
            n++;
            wait_cycle();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; load_i = 1'b0; clear_i = 1'b0; ks_ready_i = 1'b0;
        key_i = '0; iv_i = '0;
        repeat (2) wait_cycle();
        n_tests++;
        if ({busy_o, ks_valid_o, ks_data_o} !== {2'b00, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b data=%h, want 0 0 0", busy_o, ks_valid_o, ks_data_o);
        end
        reset = 1'b0;
        ks_ready_i = 1'b1;
        repeat (3) wait_cycle();
        n_tests++;
        if (busy_o !== 1'b0 || ks_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy_o, ks_valid_o);
        end
    endtask

    task automatic test_warmup_stream();
        int n;
        logic [W-1:0] e;
        model_start(80'h00112233445566778899, 80'h00000123456789abcdef, 1024);
        ks_ready_i = 1'b0;
        do_load(80'h00112233445566778899, 80'h00000123456789abcdef);
        count_busy(n);
        n_tests++;
        if (n !== CYC) begin
            n_fail++;
            $display("FAIL warmup_busy_cycles: got %0d, want %0d", n, CYC);
        end
        n_tests++;
        if (ks_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL valid_after_warmup: got %b, want 1", ks_valid_o);
        end
        ks_ready_i = 1'b1;
        for (int i = 0; i < 1024 / W; i++) begin
            e = exp_word();
            n_tests++;
            if (ks_valid_o !== 1'b1 || ks_data_o !== e) begin
                n_fail++;
                $display("FAIL stream_word[%0d]: valid=%b data=%h, want valid=1 data=%h", i, ks_valid_o, ks_data_o, e);
            end
            wait_cycle();
        end
        ks_ready_i = 1'b0;
    endtask

    task automatic test_stall();
        int n, acc, cyc;
        logic r;
        logic [W-1:0] cur;
        logic [79:0] k, v;
        k = rand80(); v = rand80();
        model_start(k, v, 64 * W);
        ks_ready_i = 1'b0;
        do_load(k, v);
        count_busy(n);
        cur = exp_word();
        acc = 0; cyc = 0;
        while (acc < 48 && cyc < 2000) begin
            r = ($urandom_range(0, 9) < 3);
            ks_ready_i = r;
            n_tests++;
            if (ks_valid_o !== 1'b1 || ks_data_o !== cur) begin
                n_fail++;
                $display("FAIL stall_word[%0d] cyc %0d: valid=%b data=%h, want valid=1 data=%h", acc, cyc, ks_valid_o, ks_data_o, cur);
            end
            wait_cycle();
            cyc++;
            if (r) begin
                acc++;
                cur = exp_word();
            end
        end
        n_tests++;
        if (acc < 48) begin
            n_fail++;
            $display("FAIL stall_budget: accepted %0d words, want 48", acc);
        end
        ks_ready_i = 1'b0;
    endtask

    task automatic test_rekey();
        int n;
        logic [W-1:0] e;
        logic [79:0] ka, va, kb, vb;
        ka = rand80(); va = rand80(); kb = rand80(); vb = rand80();
        model_start(ka, va, 8 * W);
        do_load(ka, va);
        count_busy(n);
        ks_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = exp_word();
            n_tests++;
            if (ks_data_o !== e) begin
                n_fail++;
                $display("FAIL rekey_old_word[%0d]: got %h, want %h", i, ks_data_o, e);
            end
            wait_cycle();
        end
        model_start(kb, vb, 32 * W);
        do_load(kb, vb);
        n_tests++;
        if (ks_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rekey_restart: valid=%b busy=%b, want 0 1", ks_valid_o, busy_o);
        end
        count_busy(n);
        n_tests++;
        if (n !== CYC) begin
            n_fail++;
            $display("FAIL rekey_busy_cycles: got %0d, want %0d", n, CYC);
        end
        for (int i = 0; i < 32; i++) begin
            e = exp_word();
            n_tests++;
            if (ks_valid_o !== 1'b1 || ks_data_o !== e) begin
                n_fail++;
                $display("FAIL rekey_new_word[%0d]: valid=%b data=%h, want valid=1 data=%h", i, ks_valid_o, ks_data_o, e);
            end
            wait_cycle();
        end
        ks_ready_i = 1'b0;
    endtask

    task automatic test_clear_load();
        do_load(rand80(), rand80());
        repeat (10) wait_cycle();
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre_busy: got %b, want 1", busy_o);
        end
        key_i = rand80(); iv_i = rand80();
        clear_i = 1'b1; load_i = 1'b1;
        wait_cycle();
        clear_i = 1'b0; load_i = 1'b0;
        n_tests++;
        if ({busy_o, ks_valid_o, ks_data_o} !== {2'b00, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL clear_wins: busy=%b valid=%b data=%h, want 0 0 0", busy_o, ks_valid_o, ks_data_o);
        end
`ifdef TRIVIUM_STATE_OUT_EN
        n_tests++;
        if (state_o !== 288'b0) begin
            n_fail++;
            $display("FAIL clear_state: state_o nonzero, want 0");
        end
`endif
        ks_ready_i = 1'b1;
        repeat (5) wait_cycle();
        n_tests++;
        if (busy_o !== 1'b0 || ks_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_stays_idle: busy=%b valid=%b, want 0 0", busy_o, ks_valid_o);
        end
        ks_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        logic [W-1:0] e;
        logic [79:0] k, v;
        do_load(rand80(), rand80());
        repeat (20) wait_cycle();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({busy_o, ks_valid_o, ks_data_o} !== {2'b00, {W{1'b0}}}) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b valid=%b data=%h, want 0 0 0", busy_o, ks_valid_o, ks_data_o);
        end
`ifdef TRIVIUM_STATE_OUT_EN
        n_tests++;
        if (state_o !== 288'b0) begin
            n_fail++;
            $display("FAIL async_reset_state: state_o nonzero, want 0");
        end
`endif
        #1;
        reset = 1'b0;
        wait_cycle();
        k = rand80(); v = rand80();
        model_load(k, v);
`ifdef TRIVIUM_STATE_OUT_EN
        begin
            logic [287:0] img;
            img = model_image();
            do_load(k, v);
            n_tests++;
            if (state_o !== img) begin
                n_fail++;
                $display("FAIL load_image: state_o=%h, want %h", state_o, img);
            end
        end
`else
        do_load(k, v);
`endif
        model_start(k, v, 16 * W);
        count_busy(n);
        n_tests++;
        if (n !== CYC) begin
            n_fail++;
            $display("FAIL post_reset_busy_cycles: got %0d, want %0d", n, CYC);
        end
        ks_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = exp_word();
            n_tests++;
            if (ks_valid_o !== 1'b1 || ks_data_o !== e) begin
                n_fail++;
                $display("FAIL post_reset_word[%0d]: valid=%b data=%h, want valid=1 data=%h", i, ks_valid_o, ks_data_o, e);
            end
            wait_cycle();
        end
        ks_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_warmup_stream();
        test_stall();
        test_rekey();
        test_clear_load();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
